// File: rtl/spm_ctrl_param.sv
// -----------------------------------------------------------------------------
// spm_ctrl_param
//
// Control unit for the RISC SPM processor. It runs the fetch/decode/execute
// sequence for a register file of NUM_REGS = 2**REG_SEL_W registers. It drives
// the datapath load strobes and the two bus multiplexer selects. It also
// handles a memory ready/wait-state handshake, skips the operand word of a
// conditional branch that is not taken, and raises a sticky illegal-opcode flag.
//
// Instruction layout (MSB first): {opcode[3:0], dst[REG_SEL_W-1:0], src[REG_SEL_W-1:0]}
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 RD, 6 WR, 7 BR, 8 BRZ.
// Build option SPM_CTRL_BRNZ_EN: when defined, opcode 9 is BRNZ (branch taken
// when zflag=0). When undefined, opcode 9 is illegal, like every other
// undefined opcode.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   instruction  in   IR contents (sampled only in DEC)
//   zflag        in   ALU zero flag (sampled only in DEC)
//   mem_rdy      in   memory completes the current access this cycle
//   load_reg     out  one-hot register load strobes (or all zero)
//   load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write
//                out  datapath strobes
//   mem_req      out  a memory access is in progress
//   sel_bus_1    out  0..NUM_REGS-1 selects a register, NUM_REGS selects the PC
//   sel_bus_2    out  0 = ALU, 1 = Bus_1, 2 = memory
//   halted       out  controller is in the absorbing HALT state
//   illegal_op   out  sticky flag, set when an undefined opcode is decoded
//
// Outputs are a combinational decode of the registered state. In the memory
// states, the load and increment strobes depend on mem_rdy. This lets them
// fire in the same cycle the memory completes, with no extra cycle.
// -----------------------------------------------------------------------------
module spm_ctrl_param #(
    parameter  int REG_SEL_W = 2,
    localparam int NUM_REGS  = 2**REG_SEL_W,
    localparam int INSTR_W   = 4 + 2*REG_SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                zflag,
    input  logic                mem_rdy,
    output logic [NUM_REGS-1:0] load_reg,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                load_ir,
    output logic                load_add_r,
    output logic                load_reg_y,
    output logic                load_reg_z,
    output logic                write,
    output logic                mem_req,
    output logic [REG_SEL_W:0]  sel_bus_1,
    output logic [1:0]          sel_bus_2,
    output logic                halted,
    output logic                illegal_op
);

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
`ifdef SPM_CTRL_BRNZ_EN
    localparam logic [3:0] OP_BRNZ = 4'd9;
`endif

    // Bus select encodings
    localparam logic [REG_SEL_W:0] SEL1_PC   = NUM_REGS[REG_SEL_W:0];
    localparam logic [1:0]         SEL2_ALU  = 2'd0;
    localparam logic [1:0]         SEL2_BUS1 = 2'd1;
    localparam logic [1:0]         SEL2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EXE  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
    } state_t;

    state_t               state_q, state_d;
    logic [REG_SEL_W-1:0] dst_q, dst_d;
    logic [REG_SEL_W-1:0] src_q, src_d;
    logic                 illegal_q, illegal_d;

    logic [3:0]           op_s;
    logic [REG_SEL_W-1:0] dst_s;
    logic [REG_SEL_W-1:0] src_s;

    // One-hot decode of a register index. Every index is in range because
    // NUM_REGS is exactly 2**REG_SEL_W.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] v;
        v      = {NUM_REGS{1'b0}};
        v[sel] = 1'b1;
        return v;
    endfunction

    assign op_s  = instruction[INSTR_W-1 -: 4];
    assign dst_s = instruction[2*REG_SEL_W-1 -: REG_SEL_W];
    assign src_s = instruction[REG_SEL_W-1:0];

    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

    // State, latched operand fields and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dst_q     <= {REG_SEL_W{1'b0}};
            src_q     <= {REG_SEL_W{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        src_d      = src_q;
        illegal_d  = illegal_q;
        load_reg   = {NUM_REGS{1'b0}};
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        write      = 1'b0;
        mem_req    = 1'b0;
        sel_bus_1  = {(REG_SEL_W+1){1'b0}};
        sel_bus_2  = SEL2_ALU;

        case (state_q)
            S_IDLE: begin
                state_d = S_FET1;
            end

            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                sel_bus_2  = SEL2_BUS1;
                load_add_r = 1'b1;
                state_d    = S_FET2;
            end

            S_FET2: begin
                mem_req   = 1'b1;
                sel_bus_2 = SEL2_MEM;
                if (mem_rdy) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DEC;
                end else begin
                    state_d = S_FET2;
                end
            end

            S_DEC: begin
                // Later states use the operand fields captured here, so the
                // IR may change after decode without effect.
                dst_d = dst_s;
                src_d = src_s;
                case (op_s)
                    OP_NOP: begin
                        state_d = S_FET1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: begin
                        sel_bus_1  = {1'b0, src_s};
                        sel_bus_2  = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        state_d    = S_EXE;
                    end
                    OP_RD: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = S_RD1;
                    end
                    OP_WR: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = S_WR1;
                    end
                    OP_BR: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = S_BR1;
                    end
                    OP_BRZ: begin
                        if (zflag) begin
                            sel_bus_1  = SEL1_PC;
                            sel_bus_2  = SEL2_BUS1;
                            load_add_r = 1'b1;
                            state_d    = S_BR1;
                        end else begin
                            // Not taken: step the PC past the target word.
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end
                    end
`ifdef SPM_CTRL_BRNZ_EN
                    OP_BRNZ: begin
                        if (!zflag) begin
                            sel_bus_1  = SEL1_PC;
                            sel_bus_2  = SEL2_BUS1;
                            load_add_r = 1'b1;
                            state_d    = S_BR1;
                        end else begin
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end
                    end
`endif
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end

            S_EXE: begin
                sel_bus_1  = {1'b0, dst_q};
                sel_bus_2  = SEL2_ALU;
                load_reg_z = 1'b1;
                load_reg   = reg_onehot(dst_q);
                state_d    = S_FET1;
            end

            S_RD1, S_WR1: begin
                mem_req   = 1'b1;
                sel_bus_2 = SEL2_MEM;
                if (mem_rdy) begin
                    load_add_r = 1'b1;
                    inc_pc     = 1'b1;
                    state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
                end else begin
                    state_d = state_q;
                end
            end

            S_RD2: begin
                mem_req   = 1'b1;
                sel_bus_2 = SEL2_MEM;
                if (mem_rdy) begin
                    load_reg = reg_onehot(dst_q);
                    state_d  = S_FET1;
                end else begin
                    state_d = S_RD2;
                end
            end

            S_WR2: begin
                // write is held for every cycle of the access. Memory
                // commits in the mem_rdy cycle.
                mem_req   = 1'b1;
                sel_bus_1 = {1'b0, src_q};
                write     = 1'b1;
                if (mem_rdy) begin
                    state_d = S_FET1;
                end else begin
                    state_d = S_WR2;
                end
            end

            S_BR1: begin
                mem_req   = 1'b1;
                sel_bus_2 = SEL2_MEM;
                if (mem_rdy) begin
                    load_add_r = 1'b1;
                    state_d    = S_BR2;
                end else begin
                    state_d = S_BR1;
                end
            end

            S_BR2: begin
                mem_req   = 1'b1;
                sel_bus_2 = SEL2_MEM;
                if (mem_rdy) begin
                    load_pc = 1'b1;
                    state_d = S_FET1;
                end else begin
                    state_d = S_BR2;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spm_ctrl_param.sv
module tb_spm_ctrl_param;

    typedef struct packed {
        logic [3:0] lreg;
        logic       lpc;
        logic       ipc;
        logic       lir;
        logic       lar;
        logic       lry;
        logic       lrz;
        logic       wr;
        logic       mreq;
        logic [2:0] s1;
        logic [1:0] s2;
        logic       hlt;
        logic       il;
    } outs_t;

`ifdef SPM_CTRL_BRNZ_EN
    localparam bit BRNZ_EN = 1'b1;
`else
    localparam bit BRNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zflag;
    logic       mem_rdy;
    logic [3:0] load_reg;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write;
    logic       mem_req;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic       halted, illegal_op;

    int checks   = 0;
    int failures = 0;

    outs_t q_exp[$];
    logic  q_rdy[$];
    int    dec_idx;

    spm_ctrl_param dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zflag(zflag), .mem_rdy(mem_rdy),
        .load_reg(load_reg), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
        .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
        .write(write), .mem_req(mem_req), .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
        .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o.lreg = load_reg;   o.lpc = load_pc;     o.ipc = inc_pc;     o.lir = load_ir;
        o.lar  = load_add_r; o.lry = load_reg_y;  o.lrz = load_reg_z; o.wr  = write;
        o.mreq = mem_req;    o.s1  = sel_bus_1;   o.s2  = sel_bus_2;
        o.hlt  = halted;     o.il  = illegal_op;
        return o;
    endfunction

    task automatic chk(input string tag, input outs_t e);
        outs_t obs;
        obs = sample();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic push(input outs_t o, input logic rdy);
        q_exp.push_back(o);
        q_rdy.push_back(rdy);
    endtask

    // A memory access lasting w wait cycles: `hold` outputs while waiting,
    // `fire` outputs in the completing (mem_rdy=1) cycle.
    task automatic push_mem(input outs_t hold, input outs_t fire, input int w);
        for (int k = 0; k < w; k++) push(hold, 1'b0);
        push(fire, 1'b1);
    endtask

    function automatic int waits(input bit rnd, input int fixed);
        return rnd ? int'($urandom_range(0, 2)) : fixed;
    endfunction

    // Reset is already asserted: hold it with random inputs, then release.
    task automatic reset_seq();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rdy = 1'($urandom); instruction = 8'($urandom); zflag = 1'($urandom);
            #1 chk("rst_hold", outs_t'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle", outs_t'(0));
    endtask

    // Build the expected cycle trace of one instruction from FET1, drive it,
    // and compare every cycle. The IR and zflag carry the real values only in
    // the DEC cycle and random values otherwise.
    task automatic run_instr(input string name, input logic [7:0] ins, input logic z,
                             input bit rnd, input int w_ex, input bit abort);
        outs_t o, h, f;
        logic [3:0] op;
        logic [1:0] dst, src;
        bit   halt_exp, taken, cond;
        int   last;
        op  = ins[7:4];
        dst = ins[3:2];
        src = ins[1:0];
        halt_exp = 1'b0;
        q_exp.delete();
        q_rdy.delete();

        o = '0; o.s1 = 3'd4; o.s2 = 2'd1; o.lar = 1'b1;
        push(o, 1'($urandom));
        h = '0; h.mreq = 1'b1; h.s2 = 2'd2; f = h; f.lir = 1'b1; f.ipc = 1'b1;
        push_mem(h, f, waits(rnd, 0));
        dec_idx = q_exp.size();

        cond  = (op == 4'd8) || (op == 4'd9 && BRNZ_EN);
        taken = (op == 4'd7) || (op == 4'd8 && z) || (op == 4'd9 && BRNZ_EN && !z);

        if (op == 4'd0) begin
            push(outs_t'(0), 1'($urandom));
        end else if (op >= 4'd1 && op <= 4'd4) begin
            o = '0; o.s1 = {1'b0, src}; o.s2 = 2'd1; o.lry = 1'b1;
            push(o, 1'($urandom));
            o = '0; o.s1 = {1'b0, dst}; o.lrz = 1'b1; o.lreg = 4'b0001 << dst;
            push(o, 1'($urandom));
        end else if (op == 4'd5 || op == 4'd6 || taken) begin
            o = '0; o.s1 = 3'd4; o.s2 = 2'd1; o.lar = 1'b1;
            push(o, 1'($urandom));
            h = '0; h.mreq = 1'b1; h.s2 = 2'd2;
            if (op == 4'd5 || op == 4'd6) begin
                f = h; f.lar = 1'b1; f.ipc = 1'b1;
                push_mem(h, f, waits(rnd, w_ex));
                if (op == 4'd5) begin
                    f = h; f.lreg = 4'b0001 << dst;
                    push_mem(h, f, waits(rnd, 0));
                end else begin
                    h = '0; h.mreq = 1'b1; h.s1 = {1'b0, src}; h.wr = 1'b1;
                    push_mem(h, h, waits(rnd, 0));
                end
            end else begin
                f = h; f.lar = 1'b1;
                push_mem(h, f, waits(rnd, w_ex));
                f = h; f.lpc = 1'b1;
                push_mem(h, f, waits(rnd, 0));
            end
        end else if (cond) begin
            o = '0; o.ipc = 1'b1;
            push(o, 1'($urandom));
        end else begin
            push(outs_t'(0), 1'($urandom));
            o = '0; o.hlt = 1'b1; o.il = 1'b1;
            for (int k = 0; k < 4; k++) push(o, 1'($urandom));
            halt_exp = 1'b1;
        end

        last = abort ? int'($urandom_range(0, q_exp.size() - 1)) : q_exp.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(posedge clk);
            #1;
            mem_rdy = q_rdy[i];
            if (i == dec_idx) begin
                instruction = ins; zflag = z;
            end else begin
                instruction = 8'($urandom); zflag = 1'($urandom);
            end
            @(negedge clk);
            chk($sformatf("%s_%h_c%0d", name, ins, i), q_exp[i]);
        end

        if (abort || halt_exp) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1 chk($sformatf("%s_async_rst", name), outs_t'(0));
            reset_seq();
        end
    endtask

    initial begin
        logic [7:0] ins;
        rst = 1'b1; mem_rdy = 1'b0; instruction = 8'h00; zflag = 1'b0;
        #1 chk("reset", outs_t'(0));
        reset_seq();

        run_instr("nop",     8'h00, 1'b0, 1'b0, 0, 1'b0);
        run_instr("add",     8'h16, 1'b0, 1'b0, 0, 1'b0);
        run_instr("rd_wait", 8'h5C, 1'b0, 1'b0, 2, 1'b0);
        run_instr("wr_wait", 8'h63, 1'b1, 1'b0, 1, 1'b0);
        run_instr("br",      8'h70, 1'b0, 1'b0, 0, 1'b0);
        run_instr("brz_nt",  8'h80, 1'b0, 1'b0, 0, 1'b0);
        run_instr("brz_t",   8'h80, 1'b1, 1'b0, 0, 1'b0);
        run_instr("brnz",    8'h90, 1'b0, 1'b0, 0, 1'b0);
        run_instr("illegal", 8'hF0, 1'b0, 1'b0, 0, 1'b0);
        run_instr("abort",   8'h5C, 1'b0, 1'b0, 1, 1'b1);

        for (int n = 0; n < 80; n++) begin
            ins = {4'($urandom_range(0, 11)), 4'($urandom)};
            run_instr("rnd", ins, 1'($urandom), 1'b1, 0, ($urandom_range(0, 7) == 0));
        end
        run_instr("nop_end", 8'h00, 1'b0, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spm_ctrl_param.md
# spm_ctrl_param

Parametrised next-generation control unit for the RISC SPM processor. Sequences fetch/decode/execute for a register file of 2**REG_SEL_W registers and drives the datapath load strobes and bus multiplexer selects. Adds a memory ready/wait-state handshake, correct operand skip on a not-taken branch, and an explicit illegal-opcode flag. Sits between the instruction register/Z flag and the datapath/memory.

## Interface
- REG_SEL_W, 2: register-select field width; NUM_REGS = 2**REG_SEL_W (1..3 supported).
- INSTR_W, 4+2*REG_SEL_W: instruction width, derived; fields are {opcode[3:0], dst, src}, MSB first.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  INSTR_W  IR contents.
- zflag  in  1  ALU zero flag from Reg_Z.
- mem_rdy  in  1  memory completes the current access this cycle.
- load_reg  out  NUM_REGS  one-hot register load strobes.
- load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write  out  1 each  datapath strobes.
- mem_req  out  1  memory access in progress.
- sel_bus_1  out  REG_SEL_W+1  0..NUM_REGS-1 = register, NUM_REGS = PC.
- sel_bus_2  out  2  0 = ALU, 1 = Bus_1, 2 = memory.
- halted  out  1  in HALT state.
- illegal_op  out  1  sticky; set on undefined opcode.

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 RD, 6 WR, 7 BR, 8 BRZ; others illegal (see Configuration).
- Registered state, combinational outputs. Default in every state: all strobes 0, selects 0 (no X).
- IDLE -> FET1.
- FET1: sel_bus_1=PC, sel_bus_2=1, load_add_r -> FET2.
- FET2 (mem): sel_bus_2=2, load_ir, inc_pc -> DEC.
- DEC: NOP -> FET1. ALU ops: sel_bus_1=src, sel_bus_2=1, load_reg_y -> EXE. RD/WR/BR, or BRZ with zflag=1: sel_bus_1=PC, sel_bus_2=1, load_add_r -> RD1/WR1/BR1. BRZ with zflag=0: inc_pc (skip operand word) -> FET1. Illegal: set illegal_op -> HALT.
- EXE: sel_bus_1=dst, sel_bus_2=0, load_reg_z, load_reg[dst] -> FET1.
- RD1/WR1 (mem): sel_bus_2=2, load_add_r, inc_pc -> RD2/WR2.
- RD2 (mem): sel_bus_2=2, load_reg[dst] -> FET1.
- WR2 (mem): sel_bus_1=src, write -> FET1.
- BR1 (mem): sel_bus_2=2, load_add_r -> BR2. BR2 (mem): sel_bus_2=2, load_pc -> FET1.
- HALT: absorbing until rst; halted=1.
- Memory states (FET2, RD1, RD2, WR1, WR2, BR1, BR2): mem_req=1 and selects held every cycle; remain in state while mem_rdy=0. Load/inc strobes asserted only in the mem_rdy=1 cycle. write held high for all WR2 cycles; memory commits on the mem_rdy=1 cycle.
- load_reg always one-hot or zero.

## Timing
- Reset: state=IDLE; all strobes, selects, mem_req, halted, illegal_op = 0, asynchronously.
- Cycles with mem_rdy=1 throughout, from FET1: NOP 3; ALU 4; RD/WR/BR/BRZ-taken 5; BRZ-not-taken 3.
- Each mem_rdy=0 cycle in a memory state adds exactly one cycle.
- rst mid-instruction: abort immediately, no further strobes; first FET1 one cycle after rst deasserts.
- zflag/instruction sampled only in DEC.

## Configuration
- SPM_CTRL_BRNZ_EN defined: opcode 9 = BRNZ, taken when zflag=0 (same flow as BRZ with inverted condition; not taken -> inc_pc, FET1).
- Undefined: opcode 9 illegal -> illegal_op=1, HALT.

## Test plan
- Reset then NOP (0x00), mem_rdy=1 -> FET1,FET2,DEC,FET1; load_ir and inc_pc high exactly one cycle each.
- ADD R1,R2 (0x16): DEC sel_bus_1=2, load_reg_y; EXE sel_bus_1=1, load_reg=4'b0010, load_reg_z; 4 cycles.
- RD R3 (0x5C) with mem_rdy low 2 cycles in RD1 -> 7 cycles total; inc_pc single pulse; load_reg=4'b1000 in RD2.
- BRZ (0x80) zflag=0 -> DEC asserts inc_pc, back to FET1 after 3 cycles, no load_pc; zflag=1 -> load_pc in BR2 at cycle 5.
- Opcode 0xF0 -> illegal_op=1, halted=1 permanently; rst=1 clears both asynchronously.
- Opcode 0x90, zflag=0: macro defined -> load_pc at cycle 5; undefined -> HALT, illegal_op=1.
